// File: rtl/mem_if_pkg.sv
// Shared definitions for the CPU memory-core SRAM-style interface:
// responder state encoding, bus width and strobe levels.
package mem_if_pkg;
  localparam int DATA_W = 16;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WRITE_ACT  = 2'b01,
    READ_DRIVE = 2'b10,
    ERROR      = 2'b11
  } mem_state_t;
endpackage

// File: rtl/sram_responder_resp_array.sv
// Word array with one write port and one registered read port; no reset so it
// maps onto block RAM. Same-address write-through keeps read-after-commit fresh.
module resp_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    q <= (we && waddr == raddr) ? wdata : mem[raddr];
  end
endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for the active-low SRAM-style strobes: protocol FSM,
// write latch, saturating access counters and the tri-state data bus driver.
module sram_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = mem_if_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       addr,
  inout  wire  [DATA_W-1:0] dataBus,
  input  logic              memEnable,
  input  logic              memRead,
  input  logic              memWrite,
  output logic              oor,
  output logic              err,
  output logic [CNT_W-1:0]  wrCount,
  output logic [CNT_W-1:0]  rdCount
);
  mem_state_t        state, nxt;
  logic [15:0]       wl_addr;
  logic [DATA_W-1:0] wl_data;
  logic [DATA_W-1:0] q;
  logic              rd_oor;

  logic act, rd, wr, clash, addr_oor, commit, we;

  assign act      = (memEnable == STROBE_ON);
  assign rd       = act && memRead == STROBE_ON  && memWrite == STROBE_OFF;
  assign wr       = act && memWrite == STROBE_ON && memRead == STROBE_OFF;
  assign clash    = act && memRead == STROBE_ON  && memWrite == STROBE_ON;
  assign addr_oor = |addr[15:ADDR_W];

  // The write phase ends on the first edge wr is not seen; out-of-range latches are dropped.
  assign commit = (state == WRITE_ACT) && !wr;
  assign we     = commit && !(|wl_addr[15:ADDR_W]);

  resp_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clk  (clk),
    .we   (we),
    .waddr(wl_addr[ADDR_W-1:0]),
    .wdata(wl_data),
    .raddr(addr[ADDR_W-1:0]),
    .q    (q)
  );

  assign dataBus = (state == READ_DRIVE && rd) ? (rd_oor ? '0 : q) : 'z;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:       if (clash) nxt = ERROR;
                  else if (wr) nxt = WRITE_ACT;
                  else if (rd) nxt = READ_DRIVE;
      WRITE_ACT:  if (!wr) nxt = rd ? READ_DRIVE : (clash ? ERROR : IDLE);
      READ_DRIVE: if (!rd) nxt = wr ? WRITE_ACT : (clash ? ERROR : IDLE);
      ERROR:      if (memRead == STROBE_OFF && memWrite == STROBE_OFF) nxt = IDLE;
      default:    nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      oor     <= 1'b0;
      err     <= 1'b0;
      wrCount <= '0;
      rdCount <= '0;
      wl_addr <= '0;
      wl_data <= '0;
      rd_oor  <= 1'b0;
    end else begin
      state  <= nxt;
      err    <= (nxt == ERROR);
      oor    <= addr_oor && ((nxt == WRITE_ACT  && state != WRITE_ACT) ||
                             (nxt == READ_DRIVE && state != READ_DRIVE));
      rd_oor <= addr_oor;
      if (nxt == WRITE_ACT) begin
        wl_addr <= addr;
        wl_data <= dataBus;
      end
      if (we && !(&wrCount)) wrCount <= wrCount + 1'b1;
      if (state == READ_DRIVE && !rd && !(&rdCount)) rdCount <= rdCount + 1'b1;
    end
  end
endmodule
